bgd_fade_ctrl: RTL and testbench
================================

BGD_FADE_CTRL -- requirements
Module: bgd_fade_ctrl

Interface
REQ-001 The block SHALL have parameter DIM_LEVEL, default 8, giving the dimmed brightness level in 16ths; legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port vsync, input, 1 bit: frame sync from the VGA timing block; its rising edge marks one frame.
REQ-005 The block SHALL have port fade_out_start, input, 1 bit: single-cycle request to fade to DIM_LEVEL.
REQ-006 The block SHALL have port fade_in_start, input, 1 bit: single-cycle request to fade to full brightness.
REQ-007 The block SHALL have port step_frames, input, 4 bits: frames per one-level step; the value 0 is treated as 1.
REQ-008 The block SHALL have port color_in, input, 24 bits: RGB888 pixel from the palette lookup, with R in [23:16], G in [15:8] and B in [7:0].
REQ-009 The block SHALL have port color_in_valid, input, 1 bit: color_in qualifier.
REQ-010 The block SHALL have port color_out, output, 24 bits: the scaled pixel.
REQ-011 The block SHALL have port color_out_valid, output, 1 bit: color_out qualifier.
REQ-012 The block SHALL have port level, output, 5 bits: the current brightness, 0..16, where 16 means unscaled.
REQ-013 The block SHALL have port busy, output, 1 bit: high in FADE_OUT and FADE_IN.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a fade reaches its target.

Function
REQ-015 The FSM SHALL have states BRIGHT (level=16), FADE_OUT, DIM (level=DIM_LEVEL) and FADE_IN.
REQ-016 vsync edge detection SHALL register vsync each cycle; an edge is vsync=1 with the registered value =0.
REQ-017 BRIGHT or FADE_IN with fade_out_start=1 SHALL go to FADE_OUT; the frame counter clears, step_frames is latched and level keeps its current value.
REQ-018 DIM or FADE_OUT with fade_in_start=1 SHALL go to FADE_IN with the same counter clear, step_frames latch and level hold.
REQ-019 fade_out_start asserted in FADE_OUT or DIM, or fade_in_start asserted in FADE_IN or BRIGHT, SHALL be ignored; no done pulse and no counter clear.
REQ-020 When fade_out_start and fade_in_start are asserted in the same cycle, fade_in_start SHALL take priority and fade_out_start is dropped.
REQ-021 In FADE_OUT or FADE_IN, each vsync edge SHALL increment the frame counter; when the counter reaches the latched step_frames (min 1), it clears and level steps by 1 (down in FADE_OUT, up in FADE_IN) in that same cycle.
REQ-022 The cycle in which level becomes DIM_LEVEL (FADE_OUT) or 16 (FADE_IN) SHALL move the FSM to DIM or BRIGHT respectively, and done SHALL be 1 in the following cycle only.
REQ-023 A start request and a vsync edge in the same cycle SHALL start the fade with the counter at 0; that edge is not counted.
REQ-024 level SHALL never leave the range [DIM_LEVEL, 16] and SHALL never wrap.
REQ-025 Datapath stage 1 SHALL register each channel product chan*level (13 bits) together with the valid bit; level is sampled once per pixel.
REQ-026 Datapath stage 2 SHALL register (product>>4) saturated to 255 as color_out, together with color_out_valid.
REQ-027 Latency SHALL be exactly 2 cycles, with full throughput of one pixel per cycle and no backpressure.
REQ-028 At level 16, color_out SHALL equal color_in bit-exact.
REQ-029 While color_out_valid=0, color_out SHALL hold its last value.
REQ-030 The datapath SHALL run in every FSM state, independent of busy.

Reset
REQ-031 When reset=1, the block SHALL enter BRIGHT with level=16, the frame counter at 0 and the latched step at 1.
REQ-032 When reset=1, the outputs SHALL be color_out=24'h000000, color_out_valid=0, busy=0 and done=0.
REQ-033 The registered vsync value SHALL reset to 1, so vsync held high through reset produces no edge.
REQ-034 Reset mid-fade SHALL abort the fade with no done pulse; the pipeline stages are flushed, and the valid bits clear in the cycle after reset is sampled.
REQ-035 Requests arriving while reset=1 SHALL be ignored.

Verification
REQ-036 Bench scenario, fade out: DIM_LEVEL=8, step_frames=2, pulse fade_out_start -> level reaches 14 after 4 vsync edges and 8 after 16 edges, the FSM enters DIM, done pulses once and busy falls.
REQ-037 Bench scenario, scaling: at level 8, color_in=24'hFF8040 with valid -> color_out=24'h7F4020 with valid exactly 2 cycles later; at level 16, 24'hFF8040 passes unchanged.
REQ-038 Bench scenario, reversal: at level 13 during FADE_OUT with step_frames=2, pulse fade_in_start -> level returns to 16 after 6 further edges, followed by one done pulse.
REQ-039 Bench scenario, zero step: step_frames=0 -> one level per vsync edge, reaching DIM_LEVEL=8 after 8 edges.
REQ-040 Bench scenario, simultaneous requests: fade_in_start and fade_out_start together in BRIGHT -> no state change, no done, level stays 16.
REQ-041 Bench scenario, reset: reset asserted at level 11 in FADE_OUT with 2 valid pixels in flight -> next cycle level=16, busy=0, done=0, color_out_valid=0.

Source files
------------

// File: rtl/bgd_fade_ctrl.sv
// bgd_fade_ctrl: vsync-paced brightness fade FSM plus 2-stage RGB888 scaler (clk/reset, vsync, fade requests, step_frames, color in/out, level, busy, done)
module bgd_fade_ctrl #(
   parameter int DIM_LEVEL = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        fade_out_start,
   input  logic        fade_in_start,
   input  logic [3:0]  step_frames,
   input  logic [23:0] color_in,
   input  logic        color_in_valid,
   output logic [23:0] color_out,
   output logic        color_out_valid,
   output logic [4:0]  level,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {BRIGHT, FADE_OUT, DIM, FADE_IN} state_t;
   localparam logic [4:0] LO = 5'(DIM_LEVEL);
   state_t state, state_n, rest;
   logic vsync_q, fin, fin_n, edge_v, tick, in_req, out_req, v1;
   logic [3:0] cnt, cnt_n, step_q, step_n;
   logic [4:0] level_n, tgt;
   logic [12:0] pr, pg, pb;
   function automatic logic [7:0] sat(input logic [12:0] p);
      return p[12] ? 8'hFF : p[11:4];
   endfunction
   assign edge_v = vsync & ~vsync_q;
   assign busy = state == FADE_OUT || state == FADE_IN;
   assign tick = edge_v && cnt + 4'd1 == step_q;
   assign tgt = state == FADE_OUT ? LO : 5'd16;
   assign rest = state == FADE_OUT ? DIM : BRIGHT;
   assign in_req = fade_in_start && (state == DIM || state == FADE_OUT);
   assign out_req = fade_out_start && !fade_in_start && (state == BRIGHT || state == FADE_IN);
   always_comb begin
      state_n = state;
      level_n = level;
      cnt_n = cnt;
      step_n = step_q;
      fin_n = 1'b0;
      if (in_req || out_req) begin
         state_n = in_req ? FADE_IN : FADE_OUT;
         cnt_n = 4'd0;
         step_n = step_frames == 4'd0 ? 4'd1 : step_frames;
      end else if (busy) begin
         if (level == tgt) begin
            state_n = rest;
            fin_n = 1'b1;
         end else if (edge_v) begin
            cnt_n = tick ? 4'd0 : cnt + 4'd1;
            if (tick) begin
               level_n = state == FADE_OUT ? level - 5'd1 : level + 5'd1;
               state_n = level_n == tgt ? rest : state;
               fin_n = level_n == tgt;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BRIGHT;
         level <= 5'd16;
         cnt <= 4'd0;
         step_q <= 4'd1;
         vsync_q <= 1'b1;
         fin <= 1'b0;
         done <= 1'b0;
         v1 <= 1'b0;
         pr <= '0;
         pg <= '0;
         pb <= '0;
         color_out <= 24'h000000;
         color_out_valid <= 1'b0;
      end else begin
         state <= state_n;
         level <= level_n;
         cnt <= cnt_n;
         step_q <= step_n;
         vsync_q <= vsync;
         fin <= fin_n;
         done <= fin;
         v1 <= color_in_valid;
         pr <= {5'd0, color_in[23:16]} * {8'd0, level};
         pg <= {5'd0, color_in[15:8]} * {8'd0, level};
         pb <= {5'd0, color_in[7:0]} * {8'd0, level};
         color_out_valid <= v1;
         if (v1) color_out <= {sat(pr), sat(pg), sat(pb)};
      end
   end
endmodule

// File: tb/tb_bgd_fade_ctrl.sv
// tb_bgd_fade_ctrl: directed self-checking bench for bgd_fade_ctrl
module tb_bgd_fade_ctrl;
   logic clk = 0, reset = 1, vsync = 1, fade_out_start = 0, fade_in_start = 0, color_in_valid = 0;
   logic [3:0] step_frames = 4'd1;
   logic [23:0] color_in = 24'h0, color_out;
   logic color_out_valid, busy, done;
   logic [4:0] level;
   int errors = 0, checks = 0;
   bgd_fade_ctrl #(.DIM_LEVEL(8)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .fade_out_start(fade_out_start),
      .fade_in_start(fade_in_start), .step_frames(step_frames), .color_in(color_in),
      .color_in_valid(color_in_valid), .color_out(color_out), .color_out_valid(color_out_valid),
      .level(level), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         vsync = 1;
         step();
         vsync = 0;
         step();
      end
   endtask
   task automatic start(input logic out, input logic [3:0] sf);
      step_frames = sf;
      fade_out_start = out;
      fade_in_start = !out;
      step();
      fade_out_start = 0;
      fade_in_start = 0;
   endtask
   initial begin
      step();
      step();
      reset = 0;
      step();
      vsync = 0;
      chk("rst_level", 24'(level), 24'd16);
      chk("rst_busy", 24'(busy), 24'd0);
      chk("rst_done", 24'(done), 24'd0);
      chk("rst_color", color_out, 24'h0);
      chk("rst_valid", 24'(color_out_valid), 24'd0);
      step();
      color_in = 24'hFF8040;
      color_in_valid = 1;
      step();
      color_in_valid = 0;
      color_in = 24'h123456;
      chk("l16_lat1_valid", 24'(color_out_valid), 24'd0);
      step();
      chk("l16_lat2_valid", 24'(color_out_valid), 24'd1);
      chk("l16_color", color_out, 24'hFF8040);
      step();
      chk("hold_valid", 24'(color_out_valid), 24'd0);
      chk("hold_color", color_out, 24'hFF8040);
      fade_in_start = 1;
      fade_out_start = 1;
      step();
      fade_in_start = 0;
      fade_out_start = 0;
      pulses(2);
      chk("simul_busy", 24'(busy), 24'd0);
      chk("simul_level", 24'(level), 24'd16);
      chk("simul_done", 24'(done), 24'd0);
      start(1, 4'd2);
      chk("fo_busy", 24'(busy), 24'd1);
      chk("fo_level0", 24'(level), 24'd16);
      pulses(4);
      chk("fo_level4", 24'(level), 24'd14);
      pulses(11);
      chk("fo_level15", 24'(level), 24'd9);
      chk("fo_done_early", 24'(done), 24'd0);
      pulses(1);
      chk("fo_level16", 24'(level), 24'd8);
      chk("fo_busy_end", 24'(busy), 24'd0);
      chk("fo_done", 24'(done), 24'd1);
      step();
      chk("fo_done_once", 24'(done), 24'd0);
      color_in = 24'hFF8040;
      color_in_valid = 1;
      step();
      color_in_valid = 0;
      step();
      chk("l8_valid", 24'(color_out_valid), 24'd1);
      chk("l8_color", color_out, 24'h7F4020);
      start(1, 4'd2);
      pulses(2);
      chk("dim_ign_busy", 24'(busy), 24'd0);
      chk("dim_ign_done", 24'(done), 24'd0);
      chk("dim_ign_level", 24'(level), 24'd8);
      vsync = 1;
      start(0, 4'd0);
      chk("fi_edge_busy", 24'(busy), 24'd1);
      chk("fi_edge_level", 24'(level), 24'd8);
      vsync = 0;
      step();
      pulses(1);
      chk("fi_z_level1", 24'(level), 24'd9);
      pulses(7);
      chk("fi_z_level", 24'(level), 24'd16);
      chk("fi_z_done", 24'(done), 24'd1);
      start(1, 4'd0);
      pulses(7);
      chk("fo_z_level7", 24'(level), 24'd9);
      pulses(1);
      chk("fo_z_level8", 24'(level), 24'd8);
      chk("fo_z_busy", 24'(busy), 24'd0);
      chk("fo_z_done", 24'(done), 24'd1);
      start(0, 4'd0);
      pulses(8);
      chk("back_level", 24'(level), 24'd16);
      start(1, 4'd2);
      pulses(6);
      chk("rev_level13", 24'(level), 24'd13);
      chk("rev_busy0", 24'(busy), 24'd1);
      start(0, 4'd2);
      pulses(5);
      chk("rev_level5", 24'(level), 24'd15);
      chk("rev_done_early", 24'(done), 24'd0);
      pulses(1);
      chk("rev_level6", 24'(level), 24'd16);
      chk("rev_done", 24'(done), 24'd1);
      chk("rev_busy", 24'(busy), 24'd0);
      step();
      chk("rev_done_once", 24'(done), 24'd0);
      start(1, 4'd2);
      pulses(10);
      chk("rst_mid_level11", 24'(level), 24'd11);
      color_in = 24'h808080;
      color_in_valid = 1;
      step();
      step();
      color_in_valid = 0;
      reset = 1;
      step();
      chk("rstm_level", 24'(level), 24'd16);
      chk("rstm_busy", 24'(busy), 24'd0);
      chk("rstm_done", 24'(done), 24'd0);
      chk("rstm_valid", 24'(color_out_valid), 24'd0);
      reset = 0;
      step();
      step();
      chk("rstm_no_done", 24'(done), 24'd0);
      chk("rstm_flushed", 24'(color_out_valid), 24'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
